// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package adder_pkg;
  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result valid-ready bundle between producer/consumer and the serial adder.
interface nibble_serial_adder_ctrl_if #(parameter int unsigned WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_add.sv
// 4-bit ripple adder slice built from 1-bit full-adder cells; exposes the MSB carry-in
// so the caller can form signed overflow.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module nibble_add
  import adder_pkg::*;
(
  input  logic [NIB-1:0] a_i,
  input  logic [NIB-1:0] b_i,
  input  logic           c_i,
  output logic [NIB-1:0] s_o,
  output logic           c_o,
  output logic           c_msb_o
);
  logic [NIB:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < NIB; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (s_o[i]),
      .c_o (c[i+1])
    );
  end

  assign c_o     = c[NIB];
  assign c_msb_o = c[NIB-1];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Add/subtract WIDTH-bit operands one nibble per cycle through a single 4-bit slice,
// with the carry chained through a register between steps.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int unsigned NSTEP  = WIDTH / NIB;
  localparam int unsigned STEP_W = $clog2(NSTEP);

  seq_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [NIB-1:0]    nib_a, nib_b, nib_s;
  logic              nib_c, nib_c_msb;

  assign nib_a = a_q[NIB*step_q +: NIB];
  assign nib_b = b_q[NIB*step_q +: NIB];

  nibble_add u_nibble_add (
    .a_i     (nib_a),
    .b_i     (nib_b),
    .c_i     (carry_q),
    .s_o     (nib_s),
    .c_o     (nib_c),
    .c_msb_o (nib_c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        // Subtraction is A + ~B + 1: invert B once at capture, seed carry with sub.
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[NIB*step_q +: NIB] = nib_s;
        carry_d                  = nib_c;
        if (step_q == STEP_W'(NSTEP - 1)) begin
          cout_d  = nib_c;
          ovf_d   = nib_c_msb ^ nib_c;
          state_d = S_DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready && out_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized bench for the nibble-serial adder controller, checked against
// an integer-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from signed/unsigned integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 65535);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end
    v = (sr > 32767) || (sr < -32768);
    return {v, c, ur[15:0]};
  endfunction

  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input string tag);
    logic [17:0] e;
    int cnt;
    e = model(a, b, s);
    wait_ready(tag);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.sub      = 1'($urandom);
    check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'd4);
    check({tag, "_sum"}, 32'(bus.sum), 32'(e[15:0]));
    check({tag, "_cout"}, 32'(bus.cout), 32'(e[16]));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(e[17]));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [17:0] e;
    logic [15:0] qa [3];
    logic [15:0] qb [3];
    logic        qs [3];
    logic [17:0] expq [$];
    int          cnt, idx, got, last;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h0FFF, 1'b0, "t1");
    run_op(16'hFFFF, 16'h0001, 1'b0, "t2");
    run_op(16'h7FFF, 16'h0001, 1'b0, "t3a");
    run_op(16'h0005, 16'h0007, 1'b1, "t3b");
    run_op(16'h8000, 16'h0001, 1'b1, "t3c");

    // Backpressure with ignored in_valid pulses.
    e = model(16'hA5A5, 16'h5A5A, 1'b1);
    wait_ready("t4");
    bus.a = 16'hA5A5; bus.b = 16'h5A5A; bus.sub = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'h0101; bus.b = 16'h0202; bus.sub = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      cnt++;
    end
    check("t4_latency", 32'(cnt), 32'd4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'(i % 2);
      @(negedge clk);
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_sum", 32'(bus.sum), 32'(e[15:0]));
      check("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    check("t4_cout", 32'(bus.cout), 32'(e[16]));
    check("t4_ovf", 32'(bus.ovf), 32'(e[17]));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_release_ready", 32'(bus.in_ready), 32'd1);
    check("t4_release_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the second RUN cycle discards the operation.
    wait_ready("t5");
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_sum", 32'(bus.sum), 32'd0);
    check("t5_rst_cout", 32'(bus.cout), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_idle_valid", 32'(bus.out_valid), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, "t5op");

    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), "rand");
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      qa[i] = 16'($urandom);
      qb[i] = 16'($urandom);
      qs[i] = 1'(i % 2);
    end
    wait_ready("t6");
    bus.out_ready = 1'b1;
    bus.a = qa[0]; bus.b = qb[0]; bus.sub = qs[0]; bus.in_valid = 1'b1;
    expq.push_back(model(qa[0], qb[0], qs[0]));
    idx  = 1;
    got  = 0;
    last = 0;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        e = expq.pop_front();
        check("t6_sum", 32'(bus.sum), 32'(e[15:0]));
        check("t6_flags", 32'({bus.ovf, bus.cout}), 32'(e[17:16]));
        if (got > 0) check("t6_period", 32'(cyc - last), 32'd6);
        last = cyc;
        got++;
      end
      if (bus.in_ready && idx < 3) begin
        bus.a = qa[idx]; bus.b = qb[idx]; bus.sub = qs[idx];
        expq.push_back(model(qa[idx], qb[idx], qs[idx]));
        idx++;
      end else if (!bus.in_ready && idx == 3) begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t6_count", 32'(got), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
